// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the single memory port between the Icache refill path
//                and the Dcache refill / write-back paths. One transaction is
//                latched at a time. The block drives the memory handshake and
//                returns a one-cycle ack, plus line data on reads, to the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    // Icache refill
    input  logic              ic_read_req,
    input  logic [ADDR_W-1:0] ic_read_addr,
    output logic              ic_read_ack,
    output logic [LINE_W-1:0] ic_read_data,
    // Dcache refill
    input  logic              dc_read_req,
    input  logic [ADDR_W-1:0] dc_read_addr,
    output logic              dc_read_ack,
    output logic [LINE_W-1:0] dc_read_data,
    // Dcache write-back
    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_write_ack,
    // Memory port
    output logic              mem_enable,
    output logic              mem_rw,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_data_in,
    output logic [LINE_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] c_GNT_IC = 2'd0;
    localparam logic [1:0] c_GNT_DR = 2'd1;
    localparam logic [1:0] c_GNT_DW = 2'd2;

    state_t     r_state;
    logic [1:0] r_grant;
    logic       r_last_ic;
    logic       w_pick_ic;

    // Icache wins a read grant when it is alone, or when both read paths are
    // requesting and the previous read grant went to the Dcache.
    assign w_pick_ic = ic_read_req && (!dc_read_req || !r_last_ic);

    // Arbitration FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= c_GNT_IC;
            r_last_ic    <= 1'b0;
            ic_read_ack  <= 1'b0;
            dc_read_ack  <= 1'b0;
            dc_write_ack <= 1'b0;
            ic_read_data <= '0;
            dc_read_data <= '0;
            mem_enable   <= 1'b0;
            mem_rw       <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
        end else begin
            // Acks are single-cycle pulses and are only raised on the
            // BUSY -> RESP transition below.
            ic_read_ack  <= 1'b0;
            dc_read_ack  <= 1'b0;
            dc_write_ack <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // A write-back goes first so an eviction always
                    // precedes the refill that caused it.
                    if (dc_write_req) begin
                        r_grant      <= c_GNT_DW;
                        mem_enable   <= 1'b1;
                        mem_rw       <= 1'b1;
                        mem_addr     <= dc_write_addr;
                        mem_data_out <= dc_write_data;
                        r_state      <= ST_BUSY;
                    end else if (w_pick_ic) begin
                        r_grant      <= c_GNT_IC;
                        r_last_ic    <= 1'b1;
                        mem_enable   <= 1'b1;
                        mem_rw       <= 1'b0;
                        mem_addr     <= ic_read_addr;
                        mem_data_out <= '0;
                        r_state      <= ST_BUSY;
                    end else if (dc_read_req) begin
                        r_grant      <= c_GNT_DR;
                        r_last_ic    <= 1'b0;
                        mem_enable   <= 1'b1;
                        mem_rw       <= 1'b0;
                        mem_addr     <= dc_read_addr;
                        mem_data_out <= '0;
                        r_state      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // Memory outputs are held until memory reports completion.
                    if (mem_ack) begin
                        mem_enable <= 1'b0;
                        r_state    <= ST_RESP;
                        case (r_grant)
                            c_GNT_IC: begin
                                ic_read_ack  <= 1'b1;
                                ic_read_data <= mem_data_in;
                            end
                            c_GNT_DR: begin
                                dc_read_ack  <= 1'b1;
                                dc_read_data <= mem_data_in;
                            end
                            default: begin
                                dc_write_ack <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_RESP: begin
                    // The requester drops its req at the end of this cycle,
                    // so IDLE sees the updated request set.
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. It drives
//                requests and a simple memory responder, then compares the
//                results with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_read_req;
    logic [ADDR_W-1:0] ic_read_addr;
    logic              ic_read_ack;
    logic [LINE_W-1:0] ic_read_data;
    logic              dc_read_req;
    logic [ADDR_W-1:0] dc_read_addr;
    logic              dc_read_ack;
    logic [LINE_W-1:0] dc_read_data;
    logic              dc_write_req;
    logic [ADDR_W-1:0] dc_write_addr;
    logic [LINE_W-1:0] dc_write_data;
    logic              dc_write_ack;
    logic              mem_enable;
    logic              mem_rw;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data_in;
    logic [LINE_W-1:0] mem_data_out;

    logic [2:0] w_acks;
    assign w_acks = {ic_read_ack, dc_read_ack, dc_write_ack};

    localparam logic [2:0] c_ACK_IC = 3'b100;
    localparam logic [2:0] c_ACK_DR = 3'b010;
    localparam logic [2:0] c_ACK_DW = 3'b001;

    localparam logic [LINE_W-1:0] c_D_BEEF = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
    localparam logic [LINE_W-1:0] c_D_A5   = {16{8'hA5}};
    localparam logic [LINE_W-1:0] c_D_1    = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [LINE_W-1:0] c_D_2    = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
    localparam logic [LINE_W-1:0] c_D_3    = 128'h3333_0000_0000_0000_0000_0000_0000_0003;
    localparam logic [LINE_W-1:0] c_D_4    = 128'h4444_0000_0000_0000_0000_0000_0000_0004;
    localparam logic [LINE_W-1:0] c_D_RD   = 128'h5A5A_0000_0000_0000_0000_0000_0000_0100;
    localparam logic [LINE_W-1:0] c_D_X    = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .ic_read_req   (ic_read_req),
        .ic_read_addr  (ic_read_addr),
        .ic_read_ack   (ic_read_ack),
        .ic_read_data  (ic_read_data),
        .dc_read_req   (dc_read_req),
        .dc_read_addr  (dc_read_addr),
        .dc_read_ack   (dc_read_ack),
        .dc_read_data  (dc_read_data),
        .dc_write_req  (dc_write_req),
        .dc_write_addr (dc_write_addr),
        .dc_write_data (dc_write_data),
        .dc_write_ack  (dc_write_ack),
        .mem_enable    (mem_enable),
        .mem_rw        (mem_rw),
        .mem_ack       (mem_ack),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one memory transaction: wait for the grant, check the presented
    // command, hold it for `hold` cycles, answer with mem_ack, then check the
    // ack pulse, the returned data and the following release cycle.
    task automatic serve(input string tag, input int hold, input logic [LINE_W-1:0] rdata,
                         input logic [2:0] exp_ack, input logic [ADDR_W-1:0] exp_addr,
                         input logic exp_rw, input logic [LINE_W-1:0] exp_wdata);
        int waited = 0;
        while (mem_enable !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check_val({tag, "_grant"}, 128'(mem_enable), 128'(1'b1));
        if (mem_enable !== 1'b1) return;
        check_val({tag, "_addr"}, 128'(mem_addr), 128'(exp_addr));
        check_val({tag, "_rw"}, 128'(mem_rw), 128'(exp_rw));
        check_val({tag, "_wdata"}, mem_data_out, exp_wdata);
        for (int i = 1; i < hold; i++) begin
            tick();
            check_val({tag, "_hold_en"}, 128'(mem_enable), 128'(1'b1));
            check_val({tag, "_hold_addr"}, 128'(mem_addr), 128'(exp_addr));
            check_val({tag, "_hold_noack"}, 128'(w_acks), 128'(3'b000));
        end
        mem_ack     = 1'b1;
        mem_data_in = rdata;
        tick();
        mem_ack     = 1'b0;
        mem_data_in = c_D_X;
        check_val({tag, "_ack"}, 128'(w_acks), 128'(exp_ack));
        check_val({tag, "_en_drop"}, 128'(mem_enable), 128'(1'b0));
        if (exp_ack == c_ACK_IC) check_val({tag, "_ic_data"}, ic_read_data, rdata);
        if (exp_ack == c_ACK_DR) check_val({tag, "_dc_data"}, dc_read_data, rdata);
        tick();
        check_val({tag, "_ack_gone"}, 128'(w_acks), 128'(3'b000));
        check_val({tag, "_en_gap"}, 128'(mem_enable), 128'(1'b0));
    endtask

    // At most one ack may be high in any cycle.
    always @(negedge clk) begin
        if (reset === 1'b0)
            check_val("one_ack", 128'($countones(w_acks) <= 1), 128'(1'b1));
    end

    // Stop the run if something hangs despite the bounded waits.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        ic_read_req   = 1'b0;
        ic_read_addr  = '0;
        dc_read_req   = 1'b0;
        dc_read_addr  = '0;
        dc_write_req  = 1'b0;
        dc_write_addr = '0;
        dc_write_data = '0;
        mem_ack       = 1'b0;
        mem_data_in   = '0;
        tick();
        tick();

        // Reset state
        check_val("rst_en", 128'(mem_enable), 128'(1'b0));
        check_val("rst_rw", 128'(mem_rw), 128'(1'b0));
        check_val("rst_addr", 128'(mem_addr), 128'(0));
        check_val("rst_wdata", mem_data_out, 128'(0));
        check_val("rst_acks", 128'(w_acks), 128'(3'b000));
        check_val("rst_icdata", ic_read_data, 128'(0));
        check_val("rst_dcdata", dc_read_data, 128'(0));
        reset = 1'b0;
        tick();

        // 1: single Icache read with one-cycle request-to-enable latency
        ic_read_addr = 32'h0000_0040;
        ic_read_req  = 1'b1;
        tick();
        check_val("t1_latency", 128'(mem_enable), 128'(1'b1));
        serve("t1", 4, c_D_BEEF, c_ACK_IC, 32'h40, 1'b0, 128'(0));
        ic_read_req = 1'b0;
        tick();

        // 2: write-back and refill to the same line in the same cycle; the write goes first
        dc_write_addr = 32'h100;
        dc_write_data = c_D_A5;
        dc_read_addr  = 32'h100;
        dc_write_req  = 1'b1;
        dc_read_req   = 1'b1;
        tick();
        serve("t2w", 2, c_D_X, c_ACK_DW, 32'h100, 1'b1, c_D_A5);
        dc_write_req = 1'b0;
        serve("t2r", 3, c_D_RD, c_ACK_DR, 32'h100, 1'b0, 128'(0));
        dc_read_req = 1'b0;
        tick();

        // 3: both read paths held high; grants alternate starting with the Icache
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ic_read_addr = 32'h200;
        dc_read_addr = 32'h300;
        ic_read_req  = 1'b1;
        dc_read_req  = 1'b1;
        serve("t3a", 1, c_D_1, c_ACK_IC, 32'h200, 1'b0, 128'(0));
        serve("t3b", 2, c_D_2, c_ACK_DR, 32'h300, 1'b0, 128'(0));
        check_val("t3_ic_held", ic_read_data, c_D_1);
        serve("t3c", 1, c_D_3, c_ACK_IC, 32'h200, 1'b0, 128'(0));
        check_val("t3_dc_held", dc_read_data, c_D_2);
        serve("t3d", 2, c_D_4, c_ACK_DR, 32'h300, 1'b0, 128'(0));
        ic_read_req = 1'b0;
        dc_read_req = 1'b0;
        tick();

        // 4: reset in the middle of BUSY abandons the transaction
        ic_read_addr = 32'h440;
        ic_read_req  = 1'b1;
        tick();
        check_val("t4_en", 128'(mem_enable), 128'(1'b1));
        tick();
        tick();
        reset       = 1'b1;
        ic_read_req = 1'b0;
        tick();
        reset = 1'b0;
        check_val("t4_rst_en", 128'(mem_enable), 128'(1'b0));
        check_val("t4_rst_addr", 128'(mem_addr), 128'(0));
        check_val("t4_rst_icdata", ic_read_data, 128'(0));
        check_val("t4_rst_dcdata", dc_read_data, 128'(0));
        mem_ack     = 1'b1;
        mem_data_in = c_D_X;
        tick();
        mem_ack = 1'b0;
        check_val("t4_late_noack", 128'(w_acks), 128'(3'b000));
        tick();
        check_val("t4_late_noack2", 128'(w_acks), 128'(3'b000));
        check_val("t4_late_en", 128'(mem_enable), 128'(1'b0));
        ic_read_addr = 32'h480;
        ic_read_req  = 1'b1;
        serve("t4n", 2, c_D_BEEF, c_ACK_IC, 32'h480, 1'b0, 128'(0));
        ic_read_req = 1'b0;
        tick();

        // 5: a stray mem_ack while idle is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("t5_noack", 128'(w_acks), 128'(3'b000));
            check_val("t5_noen", 128'(mem_enable), 128'(1'b0));
            tick();
        end

        // 6: back-to-back Dcache reads keep a low gap on mem_enable (checked in serve)
        dc_read_addr = 32'h600;
        dc_read_req  = 1'b1;
        serve("t6a", 1, c_D_3, c_ACK_DR, 32'h600, 1'b0, 128'(0));
        check_val("t6_gap", 128'(mem_enable), 128'(1'b0));
        serve("t6b", 1, c_D_4, c_ACK_DR, 32'h600, 1'b0, 128'(0));
        dc_read_req = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
